// File: rtl/mii_tx_frame_scheduler_if.sv
// Bus between the frame requesters / MAC frame generator and mii_tx_frame_scheduler.
// Requester k presents its descriptor at bits [16k+15:16k] of the packed vectors.
interface mii_tx_frame_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    i_req;
   logic [NUM_REQ*16-1:0] i_eth_type;
   logic [NUM_REQ*16-1:0] i_payload_length;
   logic                  i_done;
   logic [NUM_REQ-1:0]    o_gnt;
   logic                  o_start;
   logic [15:0]           o_eth_type;
   logic [15:0]           o_payload_length;
   logic                  o_len_clamp;
   logic                  o_busy;
   logic                  o_timeout;
   logic [15:0]           o_frame_count;
   logic [1:0]            dbg_state;

   // Requesters and generator side.
   modport master (
      output i_req, i_eth_type, i_payload_length, i_done,
      input  o_gnt, o_start, o_eth_type, o_payload_length, o_len_clamp,
             o_busy, o_timeout, o_frame_count, dbg_state
   );

   // Scheduler side.
   modport slave (
      input  i_req, i_eth_type, i_payload_length, i_done,
      output o_gnt, o_start, o_eth_type, o_payload_length, o_len_clamp,
             o_busy, o_timeout, o_frame_count, dbg_state
   );
endinterface

// File: rtl/mii_tx_frame_scheduler.sv
// Round-robin scheduler sharing one MAC frame generator between NUM_REQ requesters.
// Optional done watchdog is compiled in with `define MII_SCHED_WDOG_EN.
//
// Handshake: a request is a level on i_req[k]; it is taken when o_gnt[k] goes high and
// the descriptor is latched on that same edge. o_start is a one-cycle pulse telling the
// generator the descriptor is valid; the generator answers with a one-cycle i_done, which
// is only honoured while waiting for it (never in the o_start cycle). No back-pressure.
module mii_tx_frame_scheduler #(
   parameter int NUM_REQ          = 4,
   parameter int PAYLOAD_MAX_SIZE = 1500,
   parameter int IFG_CYCLES       = 12,
   parameter int WDOG_CYCLES      = 4096
) (
   input  logic                   clk,
   input  logic                   i_rst,
   mii_tx_frame_scheduler_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam logic [15:0] LEN_MAX = 16'(PAYLOAD_MAX_SIZE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q;
   logic [PTR_W-1:0]     gnt_idx_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [15:0]          eth_q, len_q, count_q;
   logic                 clamp_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic                 sel_found;
   logic [PTR_W-1:0]     sel_idx;
   logic [15:0]          sel_len;
   logic                 wdog_evt;
   logic                 frame_end;

   // Position 'off' steps above 'base', wrapping at NUM_REQ.
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   // Pick the first pending requester at or above the round-robin pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!sel_found && bus.i_req[wrap_idx(ptr_q, i)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_idx(ptr_q, i);
         end
      end
   end

   assign sel_len   = bus.i_payload_length[int'(sel_idx)*16 +: 16];
   assign frame_end = (state_q == S_WAIT) && (bus.i_done || wdog_evt);

`ifdef MII_SCHED_WDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wdog_cnt_q;
   logic            timeout_q;

   assign wdog_evt = (state_q == S_WAIT) && !bus.i_done && (wdog_cnt_q == WD_LAST);

   // Watchdog counts cycles spent waiting for done; restarts on every new wait.
   always_ff @(posedge clk) begin
      if (i_rst || state_q != S_WAIT) wdog_cnt_q <= '0;
      else                            wdog_cnt_q <= wdog_cnt_q + 1'b1;
   end

   // One-cycle abort pulse, coincident with the first gap cycle.
   always_ff @(posedge clk) begin
      if (i_rst) timeout_q <= 1'b0;
      else       timeout_q <= wdog_evt;
   end

   assign bus.o_timeout = timeout_q;
`else
   assign wdog_evt      = 1'b0;
   assign bus.o_timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (sel_found) state_d = S_START;
         S_START: state_d = S_WAIT;
         S_WAIT:  if (frame_end) state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      bus.o_busy      = (state_q != S_IDLE);
      bus.o_start     = (state_q == S_START);
      bus.o_len_clamp = (state_q == S_START) && clamp_q;
      bus.dbg_state   = state_q;
   end

   // Grant and descriptor capture; descriptor stays put between frames.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         eth_q     <= '0;
         len_q     <= '0;
         clamp_q   <= 1'b0;
      end else if (state_q == S_IDLE && sel_found) begin
         gnt_q     <= NUM_REQ'(1) << sel_idx;
         gnt_idx_q <= sel_idx;
         eth_q     <= bus.i_eth_type[int'(sel_idx)*16 +: 16];
         len_q     <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
         clamp_q   <= (sel_len > LEN_MAX);
      end else if (frame_end) begin
         gnt_q     <= '0;
      end
   end

   // Round-robin pointer moves past the served requester; count only real completions.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (frame_end) begin
         ptr_q <= (int'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + 1'b1;
         if (bus.i_done) count_q <= count_q + 16'd1;
      end
   end

   // Inter-frame gap counter, idle at zero outside the gap.
   always_ff @(posedge clk) begin
      if (i_rst || state_q != S_GAP) gap_cnt_q <= '0;
      else                           gap_cnt_q <= gap_cnt_q + 1'b1;
   end

   assign bus.o_gnt            = gnt_q;
   assign bus.o_eth_type       = eth_q;
   assign bus.o_payload_length = len_q;
   assign bus.o_frame_count    = count_q;
endmodule

// File: tb/tb_mii_tx_frame_scheduler.sv
// Bench for mii_tx_frame_scheduler: one instance with a 12-cycle gap, one with no gap,
// both driven from the same inputs; the active one is selected by use2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mii_tx_frame_scheduler;
   localparam int NR   = 4;
   localparam int MAXL = 1500;
   localparam int IFG  = 12;
   localparam int WD   = 16;

   logic clk = 1'b0;
   logic rst;
   logic use2;
   logic [NR-1:0]    req_drv;
   logic [NR*16-1:0] eth_drv, len_drv;
   logic             done_drv;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          m_ptr;
   int          m_count;
   logic [3:0]  req_vec;

   mii_tx_frame_scheduler_if #(.NUM_REQ(NR)) b1 ();
   mii_tx_frame_scheduler_if #(.NUM_REQ(NR)) b2 ();

   assign b1.i_req = req_drv;  assign b1.i_eth_type = eth_drv;
   assign b1.i_payload_length = len_drv;  assign b1.i_done = done_drv;
   assign b2.i_req = req_drv;  assign b2.i_eth_type = eth_drv;
   assign b2.i_payload_length = len_drv;  assign b2.i_done = done_drv;

   mii_tx_frame_scheduler #(.NUM_REQ(NR), .PAYLOAD_MAX_SIZE(MAXL), .IFG_CYCLES(IFG),
                            .WDOG_CYCLES(WD)) dut1 (.clk(clk), .i_rst(rst), .bus(b1));
   mii_tx_frame_scheduler #(.NUM_REQ(NR), .PAYLOAD_MAX_SIZE(MAXL), .IFG_CYCLES(0),
                            .WDOG_CYCLES(WD)) dut2 (.clk(clk), .i_rst(rst), .bus(b2));

   wire [3:0]  v_gnt     = use2 ? b2.o_gnt            : b1.o_gnt;
   wire        v_start   = use2 ? b2.o_start          : b1.o_start;
   wire        v_busy    = use2 ? b2.o_busy           : b1.o_busy;
   wire        v_clamp   = use2 ? b2.o_len_clamp      : b1.o_len_clamp;
   wire        v_timeout = use2 ? b2.o_timeout        : b1.o_timeout;
   wire [15:0] v_eth     = use2 ? b2.o_eth_type       : b1.o_eth_type;
   wire [15:0] v_len     = use2 ? b2.o_payload_length : b1.o_payload_length;
   wire [15:0] v_count   = use2 ? b2.o_frame_count    : b1.o_frame_count;

   // Clock and global time limit
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int gap_len();
      return use2 ? 0 : IFG;
   endfunction

   // Spec rule: first pending requester searching upward from the pointer, wrapping.
   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < NR; i++)
         if (r[(p + i) % NR]) return (p + i) % NR;
      return 0;
   endfunction

   task automatic set_desc(input int k, input logic [15:0] t, input logic [15:0] l);
      eth_drv[k*16 +: 16] = t;
      len_drv[k*16 +: 16] = l;
   endtask

   task automatic rand_desc();
      for (int k = 0; k < NR; k++) begin
         logic [15:0] l;
         case ($urandom_range(0, 3))
            0:       l = 16'($urandom_range(0, MAXL));
            1:       l = 16'(MAXL);
            2:       l = 16'(MAXL + 1);
            default: l = 16'($urandom_range(0, 65535));
         endcase
         set_desc(k, 16'($urandom_range(0, 65535)), l);
      end
   endtask

   task automatic apply_req(input logic [3:0] r);
      req_vec = r;
      req_drv = r;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply_req(4'b0000);
      done_drv = 1'b0;
      step();
      step();
      rst = 1'b0;
      m_ptr   = 0;
      m_count = 0;
   endtask

   // Wait for o_start; it must arrive exactly exp_lat cycles from now.
   task automatic wait_start(input int exp_lat);
      int n;
      n = 0;
      for (int i = 0; i < exp_lat + 4; i++) begin
         step();
         n++;
         if (v_start === 1'b1) break;
         check("gnt_before_start", 32'(v_gnt), 32'd0);
      end
      check("start_latency", n, exp_lat);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (v_busy !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      check("drain_idle", 32'(v_busy), 32'd0);
   endtask

   // One complete frame from grant to the cycle after done.
   task automatic frame(input int exp_lat, input int hold, input bit early_done,
                        input bit drop_own, input logic [3:0] nxt_req);
      int          w;
      logic [15:0] et, raw, el;
      logic        ec;
      logic [3:0]  eg;
      w   = pick(req_vec, m_ptr);
      eg  = 4'b0001 << w;
      et  = eth_drv[w*16 +: 16];
      raw = len_drv[w*16 +: 16];
      ec  = (int'(raw) > MAXL);
      el  = ec ? 16'(MAXL) : raw;
      wait_start(exp_lat);
      check("gnt", 32'(v_gnt), 32'(eg));
      check("eth_type", 32'(v_eth), 32'(et));
      check("payload_len", 32'(v_len), 32'(el));
      check("len_clamp", 32'(v_clamp), 32'(ec));
      check("busy_start", 32'(v_busy), 32'd1);
      if (early_done) done_drv = 1'b1;
      if (drop_own) apply_req(req_vec & ~eg);
      set_desc(w, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      for (int i = 0; i < hold; i++) begin
         step();
         done_drv = 1'b0;
         check("start_pulse", 32'(v_start), 32'd0);
         check("gnt_hold", 32'(v_gnt), 32'(eg));
         check("len_hold", 32'(v_len), 32'(el));
         check("count_wait", 32'(v_count), 32'(m_count));
      end
      step();
      done_drv = 1'b1;
      apply_req(nxt_req);
      m_count = (m_count + 1) % 65536;
      m_ptr   = (w + 1) % NR;
      step();
      done_drv = 1'b0;
      check("gnt_clear", 32'(v_gnt), 32'd0);
      check("frame_count", 32'(v_count), 32'(m_count));
      check("busy_after_done", 32'(v_busy), 32'(gap_len() > 0));
      check("eth_held", 32'(v_eth), 32'(et));
      check("timeout_idle", 32'(v_timeout), 32'd0);
   endtask

   task automatic random_frames(input int n_frames);
      int lat;
      rand_desc();
      apply_req(4'($urandom_range(1, 15)));
      lat = 1;
      for (int k = 0; k < n_frames; k++) begin
         logic [3:0] nxt;
         nxt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         frame(lat, $urandom_range(0, 8), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), nxt);
         rand_desc();
         if (nxt == 4'd0) begin
            drain();
            repeat ($urandom_range(0, 3)) step();
            apply_req(4'($urandom_range(1, 15)));
            lat = 1;
         end else begin
            lat = gap_len() + 1;
         end
      end
      apply_req(4'b0000);
      drain();
   endtask

   initial begin
      logic [15:0] clamp_tab [5];
      int          lat;
      use2 = 1'b0;
      done_drv = 1'b0;
      eth_drv = '0;
      len_drv = '0;
      do_reset();

      // Reset state
      check("rst_gnt", 32'(v_gnt), 32'd0);
      check("rst_busy", 32'(v_busy), 32'd0);
      check("rst_start", 32'(v_start), 32'd0);
      check("rst_count", 32'(v_count), 32'd0);
      check("rst_eth", 32'(v_eth), 32'd0);
      check("rst_len", 32'(v_len), 32'd0);
      check("rst_timeout", 32'(v_timeout), 32'd0);
      step();

      // Single request, then the full 12-cycle gap
      set_desc(2, 16'h0800, 16'd64);
      apply_req(4'b0100);
      frame(1, 5, 1'b0, 1'b1, 4'b0000);
      for (int i = 2; i <= IFG; i++) begin
         step();
         check("gap_busy", 32'(v_busy), 32'd1);
         check("gap_gnt", 32'(v_gnt), 32'd0);
      end
      step();
      check("gap_end_idle", 32'(v_busy), 32'd0);
      check("idle_len_held", 32'(v_len), 32'd64);

      // Reset in the middle of waiting for done
      set_desc(1, 16'h86DD, 16'd100);
      apply_req(4'b0010);
      wait_start(1);
      check("pre_rst_gnt", 32'(v_gnt), 32'h2);
      step();
      step();
      do_reset();
      check("midrst_gnt", 32'(v_gnt), 32'd0);
      check("midrst_busy", 32'(v_busy), 32'd0);
      check("midrst_count", 32'(v_count), 32'd0);
      step();
      check("midrst_no_start", 32'(v_start), 32'd0);

      // Round robin with every requester pending
      for (int k = 0; k < NR; k++) set_desc(k, 16'(16'h0100 + k), 16'(46 + k));
      apply_req(4'b1111);
      lat = 1;
      for (int k = 0; k < 5; k++) begin
         frame(lat, 3, 1'b0, 1'b0, (k == 4) ? 4'b0000 : 4'b1111);
         lat = gap_len() + 1;
      end
      drain();

      // Length clamp and its boundaries, requester 1 back-to-back
      clamp_tab[0] = 16'd2000;  clamp_tab[1] = 16'd1500;  clamp_tab[2] = 16'd1501;
      clamp_tab[3] = 16'd0;     clamp_tab[4] = 16'hFFFF;
      apply_req(4'b0010);
      lat = 1;
      for (int k = 0; k < 5; k++) begin
         set_desc(1, 16'h88B5, clamp_tab[k]);
         frame(lat, 2, 1'b1, 1'b0, (k == 4) ? 4'b0000 : 4'b0010);
         lat = gap_len() + 1;
      end
      drain();

`ifdef MII_SCHED_WDOG_EN
      // Watchdog: no done ever arrives
      begin
         int w, n;
         rand_desc();
         apply_req(4'b1111);
         w = pick(req_vec, m_ptr);
         wait_start(1);
         n = 0;
         for (int i = 0; i < WD + 5; i++) begin
            step();
            n++;
            if (v_timeout === 1'b1) break;
         end
         check("wdog_latency", n, WD + 1);
         check("wdog_gnt", 32'(v_gnt), 32'd0);
         check("wdog_count", 32'(v_count), 32'(m_count));
         m_ptr = (w + 1) % NR;
         step();
         check("wdog_pulse_width", 32'(v_timeout), 32'd0);
         frame(gap_len(), 2, 1'b0, 1'b0, 4'b0000);
         drain();
      end
`endif

      random_frames(30);

      // Zero-gap instance: back-to-back starts two cycles after done
      use2 = 1'b1;
      do_reset();
      check("rst2_busy", 32'(v_busy), 32'd0);
      check("rst2_count", 32'(v_count), 32'd0);
      rand_desc();
      apply_req(4'b1111);
      frame(1, 0, 1'b0, 1'b0, 4'b1111);
      frame(1, 4, 1'b0, 1'b0, 4'b0000);
      drain();
      random_frames(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
